byte_hex_formatter: RTL and testbench

Sits between the receive byte FIFO and uart_tx in the MII-to-serial path. Converts each captured MII byte into two upper-case ASCII hex characters plus a separator, and inserts CR/LF at line/frame boundaries, so frames are human-readable on a terminal. Pulls bytes with a valid/ready handshake and paces the UART using its DV/Active handshake.

---
 rtl/byte_hex_formatter_pkg.sv | 30 +++
 rtl/byte_hex_formatter.sv | 128 ++++++++++++
 tb/tb_byte_hex_formatter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/byte_hex_formatter_pkg.sv
// Shared constants, state encoding and nibble mapping
// for the byte-to-ASCII-hex terminal formatter.
package byte_hex_formatter_pkg;

    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_0     = 8'h30;
    localparam logic [7:0] CHAR_A     = 8'h41;

    typedef enum logic [2:0] {
        IDLE,
        HI,
        LO,
        SEP,
        CR,
        LF,
        WAIT
    } state_t;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        logic [7:0] wide;
        wide = {4'd0, nib};
        if (nib < 4'd10)
            return CHAR_0 + wide;
        else
            return CHAR_A + (wide - 8'd10);
    endfunction

endpackage

// File: rtl/byte_hex_formatter.sv
// Turns upstream bytes into upper-case hex text with separators
// and CR/LF line breaks, paced by the UART's DV/Active handshake.
module byte_hex_formatter
    import byte_hex_formatter_pkg::*;
#(
    parameter int unsigned BYTES_PER_LINE = 16,
    parameter logic [7:0]  SEP_CHAR       = 8'h20,
    parameter int unsigned GUARD_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic       tx_dv,
    output logic [7:0] tx_byte,
    input  logic       tx_active
);

    localparam int GUARD_W = (GUARD_CYCLES < 1) ? 1 : $clog2(GUARD_CYCLES + 1);

    state_t             state;
    state_t             ret_state;
    state_t             state_nxt;
    logic [3:0]         lo_nib;
    logic               last;
    logic [7:0]         line_cnt;
    logic [GUARD_W-1:0] guard_cnt;
    logic               guard_done;
    logic               capture;
    logic               line_end;
    logic               issue_nxt;
    logic [7:0]         char_nxt;

    assign in_ready   = (state == IDLE) && !reset;
    assign capture    = in_valid && in_ready;
    assign guard_done = (guard_cnt == GUARD_W'(GUARD_CYCLES));
    assign line_end   = last || (({1'b0, line_cnt} + 9'd1) == 9'(BYTES_PER_LINE));

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (capture) state_nxt = HI;
            HI, LO, SEP, CR, LF: state_nxt = WAIT;
            WAIT: if (guard_done && !tx_active) state_nxt = ret_state;
            default: state_nxt = IDLE;
        endcase
    end

    // Output registers are loaded from the next state so the pulse
    // lines up with the issue state itself and WAIT sees tx_dv low.
    always_comb begin
        issue_nxt = 1'b0;
        char_nxt  = tx_byte;
        unique case (state_nxt)
            HI: begin
                issue_nxt = 1'b1;
                char_nxt  = nibble_to_ascii(in_data[7:4]);
            end
            LO: begin
                issue_nxt = 1'b1;
                char_nxt  = nibble_to_ascii(lo_nib);
            end
            SEP: begin
                issue_nxt = 1'b1;
                char_nxt  = SEP_CHAR;
            end
            CR: begin
                issue_nxt = 1'b1;
                char_nxt  = CHAR_CR;
            end
            LF: begin
                issue_nxt = 1'b1;
                char_nxt  = CHAR_LF;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ret_state <= IDLE;
            lo_nib    <= '0;
            last      <= 1'b0;
            line_cnt  <= '0;
            guard_cnt <= '0;
            tx_dv     <= 1'b0;
            tx_byte   <= 8'h00;
        end else begin
            state   <= state_nxt;
            tx_dv   <= issue_nxt;
            tx_byte <= char_nxt;
            if (capture) begin
                lo_nib <= in_data[3:0];
                last   <= in_last;
            end
            unique case (state)
                HI: begin
                    ret_state <= LO;
                    guard_cnt <= '0;
                end
                LO: begin
                    ret_state <= line_end ? CR : SEP;
                    guard_cnt <= '0;
                end
                SEP: begin
                    ret_state <= IDLE;
                    line_cnt  <= line_cnt + 8'd1;
                    guard_cnt <= '0;
                end
                CR: begin
                    ret_state <= LF;
                    line_cnt  <= '0;
                    guard_cnt <= '0;
                end
                LF: begin
                    ret_state <= IDLE;
                    guard_cnt <= '0;
                end
                WAIT: if (!guard_done) guard_cnt <= guard_cnt + GUARD_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_hex_formatter.sv
// Scoreboard bench for byte_hex_formatter: a text-level reference
// model fills an expected-character queue, a monitor drains it.
module tb_byte_hex_formatter;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_active;

    int total = 0;
    int bad = 0;
    int dv_count = 0;
    int busy_len = 10;
    int busy_cnt = 0;
    int m_cnt = 0;
    logic [7:0] exp_q[$];
    string hexdig = "0123456789ABCDEF";

    always #5 clk = ~clk;

    byte_hex_formatter dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .tx_dv     (tx_dv),
        .tx_byte   (tx_byte),
        .tx_active (tx_active)
    );

    // UART stand-in: busy from the cycle after dv for busy_len cycles
    always @(posedge clk) begin
        if (reset) begin
            tx_active <= 1'b0;
            busy_cnt  <= 0;
        end else if (tx_dv) begin
            tx_active <= 1'b1;
            busy_cnt  <= busy_len;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            busy_cnt  <= 0;
            tx_active <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!reset && tx_dv) begin
            logic [7:0] e;
            dv_count++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL tx_char got=%h exp=<none>", tx_byte);
            end else begin
                e = exp_q.pop_front();
                if (tx_byte !== e) begin
                    bad++;
                    $display("FAIL tx_char got=%h exp=%h", tx_byte, e);
                end
            end
            total++;
            if (tx_active) begin
                bad++;
                $display("FAIL dv_overlap got=tx_active=1 exp=0");
            end
        end
    end

    function automatic void model_push(input logic [7:0] d, input logic l);
        exp_q.push_back(hexdig[d / 16]);
        exp_q.push_back(hexdig[d % 16]);
        if (l || m_cnt + 1 == 16) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
            m_cnt = 0;
        end else begin
            exp_q.push_back(8'h20);
            m_cnt = m_cnt + 1;
        end
    endfunction

    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout got=in_ready=0 exp=1");
        end else begin
            model_push(d, l);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 5000) begin
            bad++;
            $display("FAIL %s drain got=left=%0d exp=0", name, exp_q.size());
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int n;
        logic rdy_seen;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_tx_dv", 32'(tx_dv), 0);
        check("rst_tx_byte", 32'(tx_byte), 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_in_ready", 32'(in_ready), 1);

        busy_len = 10;
        send(8'hA5, 1'b0);
        drain("a5");
        check("a5_in_ready", 32'(in_ready), 1);

        send(8'h0F, 1'b1);
        drain("0f_last");

        for (int i = 0; i <= 16; i++)
            send(8'(i), i == 16);
        drain("line_wrap");

        busy_len = 200;
        start = dv_count;
        send(8'h55, 1'b0);
        n = 0;
        while (dv_count == start && n < 50) begin
            @(negedge clk);
            n++;
        end
        rdy_seen = 1'b0;
        repeat (190) begin
            @(negedge clk);
            if (in_ready) rdy_seen = 1'b1;
        end
        check("bp_dv_pulses", 32'(dv_count - start), 1);
        check("bp_in_ready", 32'(rdy_seen), 0);
        busy_len = 10;
        drain("backpressure");

        start = dv_count;
        send(8'h77, 1'b0);
        n = 0;
        while (dv_count < start + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("lo_dv_seen", 32'(dv_count - start), 2);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        m_cnt = 0;
        @(posedge clk);
        #1;
        check("mid_rst_tx_dv", 32'(tx_dv), 0);
        check("mid_rst_in_ready", 32'(in_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(in_ready), 1);
        send(8'h3C, 1'b0);
        drain("after_reset");

        send(8'h9A, 1'b0);
        send(8'hBF, 1'b0);
        drain("nibble_sweep");

        while (m_cnt != 15)
            send(8'($urandom), 1'b0);
        send(8'hC3, 1'b1);
        drain("full_line_last");

        for (int i = 0; i < 60; i++) begin
            busy_len = $urandom_range(1, 12);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(8'($urandom), $urandom_range(0, 7) == 0);
        end
        drain("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
